// File: rtl/lii_axi_bridge_mt.sv
// AXI4 single-ID slave to LII request/response stream bridge with tagged,
// multi-outstanding reads and writes and round-robin AW/AR arbitration.
module lii_axi_bridge_mt #(
  parameter int AXI_AW  = 48,
  parameter int AXI_DW  = 64,
  parameter int LII_DW  = 1024,
  parameter int MAX_OUT = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  // AXI read address / data
  input  logic [AXI_AW-1:0]     aximm_araddr,
  input  logic [7:0]            aximm_arlen,
  input  logic [2:0]            aximm_arsize,
  input  logic                  aximm_arvalid,
  output logic                  aximm_arready,
  output logic [AXI_DW-1:0]     aximm_rdata,
  output logic [1:0]            aximm_rresp,
  output logic                  aximm_rlast,
  output logic                  aximm_rvalid,
  input  logic                  aximm_rready,
  // AXI write address / data / response
  input  logic [AXI_AW-1:0]     aximm_awaddr,
  input  logic [7:0]            aximm_awlen,
  input  logic [2:0]            aximm_awsize,
  input  logic                  aximm_awvalid,
  output logic                  aximm_awready,
  input  logic [AXI_DW-1:0]     aximm_wdata,
  input  logic [AXI_DW/8-1:0]   aximm_wstrb,
  input  logic                  aximm_wlast,
  input  logic                  aximm_wvalid,
  output logic                  aximm_wready,
  output logic [1:0]            aximm_bresp,
  output logic                  aximm_bvalid,
  input  logic                  aximm_bready,
  // LII request stream
  output logic [LII_DW-1:0]     lii_req_tdata,
  output logic [LII_DW/8-1:0]   lii_req_tkeep,
  output logic [LII_DW/8-1:0]   lii_req_tstrb,
  output logic                  lii_req_tlast,
  output logic [7:0]            lii_req_src,
  output logic [7:0]            lii_req_dst,
  output logic                  lii_req_tvalid,
  input  logic                  lii_req_tready,
  // LII response stream
  input  logic [LII_DW-1:0]     lii_resp_tdata,
  input  logic [LII_DW/8-1:0]   lii_resp_tkeep,
  input  logic [LII_DW/8-1:0]   lii_resp_tstrb,
  input  logic                  lii_resp_tlast,
  input  logic [7:0]            lii_resp_src,
  input  logic [7:0]            lii_resp_dst,
  input  logic                  lii_resp_tvalid,
  output logic                  lii_resp_tready,
  // static route, status
  input  logic [7:0]            cfg_src,
  input  logic [7:0]            cfg_dst,
  output logic [6:0]            rd_outstanding,
  output logic [6:0]            wr_outstanding,
  output logic                  err_tag,
  input  logic                  err_clr
);

  localparam int HDR_W = 2 + 8 + 3 + AXI_AW + 8;
  localparam int SW    = AXI_DW / 8;
  localparam logic [6:0] MAX_CNT = 7'(MAX_OUT);

  localparam logic [1:0] OP_RD    = 2'b00;
  localparam logic [1:0] OP_WR    = 2'b01;
  localparam logic [1:0] OP_RDATA = 2'b10;
  localparam logic [1:0] OP_WACK  = 2'b11;

  typedef enum logic [1:0] {IDLE, HDR_RD, HDR_WR, SEND_W} state_t;

  state_t            state, state_nxt;
  logic [AXI_AW-1:0] hdr_addr;
  logic [7:0]        hdr_len;
  logic [2:0]        hdr_size;
  logic [6:0]        rd_seq, wr_seq, rd_exp, wr_exp, rd_cnt, wr_cnt;
  logic              rr_rd, err_q;

  logic rd_ok, wr_ok, ar_hs, aw_hs, rd_hdr_hs, wr_hdr_hs;
  logic [1:0] resp_op, resp_code;
  logic [7:0] resp_tag;
  logic rd_match, wr_match, resp_bad, rd_done, wr_done;
  logic resp_unused;

  function automatic logic [6:0] cnt_next(input logic [6:0] c, input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return c + 7'd1;
      2'b01:   return c - 7'd1;
      default: return c;
    endcase
  endfunction

  // Address arbitration: the rr pointer only breaks ties when both directions can go
  assign rd_ok = (rd_cnt < MAX_CNT);
  assign wr_ok = (wr_cnt < MAX_CNT);
  assign aximm_arready = rstn && (state == IDLE) && rd_ok && !(aximm_awvalid && wr_ok && !rr_rd);
  assign aximm_awready = rstn && (state == IDLE) && wr_ok && !(aximm_arvalid && rd_ok && rr_rd);
  assign aximm_wready  = (state == SEND_W) && lii_req_tready;

  assign ar_hs     = aximm_arvalid && aximm_arready;
  assign aw_hs     = aximm_awvalid && aximm_awready;
  assign rd_hdr_hs = (state == HDR_RD) && lii_req_tready;
  assign wr_hdr_hs = (state == HDR_WR) && lii_req_tready;

  always_comb begin
    state_nxt      = state;
    lii_req_tvalid = 1'b0;
    lii_req_tlast  = 1'b0;
    lii_req_tdata  = '0;
    lii_req_tkeep  = '0;
    lii_req_tstrb  = '0;
    lii_req_src    = 8'd0;
    lii_req_dst    = 8'd0;
    case (state)
      IDLE: begin
        if (aw_hs)      state_nxt = HDR_WR;
        else if (ar_hs) state_nxt = HDR_RD;
      end
      HDR_RD: begin
        lii_req_tvalid = 1'b1;
        lii_req_tlast  = 1'b1;
        lii_req_tdata[LII_DW-1 -: HDR_W] = {OP_RD, hdr_len, hdr_size, hdr_addr, 1'b0, rd_seq};
        lii_req_tkeep  = '1;
        lii_req_src    = cfg_src;
        lii_req_dst    = cfg_dst;
        if (lii_req_tready) state_nxt = IDLE;
      end
      HDR_WR: begin
        lii_req_tvalid = 1'b1;
        lii_req_tdata[LII_DW-1 -: HDR_W] = {OP_WR, hdr_len, hdr_size, hdr_addr, 1'b1, wr_seq};
        lii_req_tkeep  = '1;
        lii_req_src    = cfg_src;
        lii_req_dst    = cfg_dst;
        if (lii_req_tready) state_nxt = SEND_W;
      end
      SEND_W: begin
        lii_req_tvalid = aximm_wvalid;
        lii_req_tlast  = aximm_wlast;
        lii_req_tdata[AXI_DW-1:0] = aximm_wdata;
        lii_req_tkeep[SW-1:0]     = aximm_wstrb;
        lii_req_tstrb[SW-1:0]     = aximm_wstrb;
        lii_req_src    = cfg_src;
        lii_req_dst    = cfg_dst;
        if (aximm_wvalid && lii_req_tready && aximm_wlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response decode: only the next expected in-order tag is forwarded to AXI
  assign resp_op   = lii_resp_tdata[LII_DW-1 -: 2];
  assign resp_tag  = lii_resp_tdata[LII_DW-3 -: 8];
  assign resp_code = lii_resp_tdata[LII_DW-11 -: 2];

  assign rd_match = rstn && lii_resp_tvalid && (resp_op == OP_RDATA) &&
                    (resp_tag == {1'b0, rd_exp}) && (rd_cnt != 7'd0);
  assign wr_match = rstn && lii_resp_tvalid && (resp_op == OP_WACK) &&
                    (resp_tag == {1'b1, wr_exp}) && (wr_cnt != 7'd0);
  assign resp_bad = rstn && lii_resp_tvalid && !rd_match && !wr_match;

  assign aximm_rvalid = rd_match;
  assign aximm_rdata  = rd_match ? lii_resp_tdata[AXI_DW-1:0] : '0;
  assign aximm_rresp  = rd_match ? resp_code : 2'b00;
  assign aximm_rlast  = rd_match && lii_resp_tlast;
  assign aximm_bvalid = wr_match;
  assign aximm_bresp  = wr_match ? resp_code : 2'b00;

  assign lii_resp_tready = rd_match ? aximm_rready : (wr_match ? aximm_bready : rstn);

  assign rd_done = rd_match && aximm_rready && lii_resp_tlast;
  assign wr_done = wr_match && aximm_bready;

  assign resp_unused = ^{lii_resp_tkeep, lii_resp_tstrb, lii_resp_src, lii_resp_dst,
                         lii_resp_tdata[LII_DW-13:AXI_DW]};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      rr_rd  <= 1'b0;
      rd_seq <= 7'd0;
      wr_seq <= 7'd0;
      rd_exp <= 7'd0;
      wr_exp <= 7'd0;
      rd_cnt <= 7'd0;
      wr_cnt <= 7'd0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      if (ar_hs || aw_hs) rr_rd <= ~rr_rd;
      if (rd_hdr_hs) rd_seq <= rd_seq + 7'd1;
      if (wr_hdr_hs) wr_seq <= wr_seq + 7'd1;
      if (rd_done)   rd_exp <= rd_exp + 7'd1;
      if (wr_done)   wr_exp <= wr_exp + 7'd1;
      rd_cnt <= cnt_next(rd_cnt, rd_hdr_hs, rd_done);
      wr_cnt <= cnt_next(wr_cnt, wr_hdr_hs, wr_done);
      if (resp_bad)     err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  // Header fields are only visible in the header states, so they carry no reset
  always_ff @(posedge clk) begin
    if (ar_hs) begin
      hdr_addr <= aximm_araddr;
      hdr_len  <= aximm_arlen;
      hdr_size <= aximm_arsize;
    end else if (aw_hs) begin
      hdr_addr <= aximm_awaddr;
      hdr_len  <= aximm_awlen;
      hdr_size <= aximm_awsize;
    end
  end

  assign rd_outstanding = rd_cnt;
  assign wr_outstanding = wr_cnt;
  assign err_tag        = err_q;

endmodule
